// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: a 3-cycle pulsed-read fetch FSM feeding a prefetch FIFO with redirect flush.
// Optional build macro FETCH_MISALIGN_TRAP_EN adds fetch_fault and halts fetching on misaligned redirects.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output logic [31:0]                   inst_address,
  output logic                          inst_read,
  input  logic [31:0]                   inst_in,
  input  logic                          redirect_valid,
  input  logic [31:0]                   redirect_pc,
  input  logic                          deq_ready,
  output logic                          fetch_valid,
  output logic [31:0]                   fetch_inst,
  output logic [31:0]                   fetch_pc,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic                          fetch_fault
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_CAPT = 2'd2
  } state_t;

  state_t           r_state;
  logic [31:0]      r_pc;
  logic             r_read;
  logic [31:0]      r_inst_mem [FIFO_DEPTH];
  logic [31:0]      r_pc_mem   [FIFO_DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_push;
  logic             w_pop;
  logic             w_parked;
  logic             w_can_fetch;
  logic [31:0]      w_redirect_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic r_fault;

  // A misaligned target is kept unmasked so the faulting address stays visible on inst_address.
  assign w_parked      = r_fault;
  assign w_redirect_pc = redirect_pc;
  assign fetch_fault   = r_fault;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fault <= 1'b0;
    end else if (redirect_valid) begin
      r_fault <= (redirect_pc[1:0] != 2'b00);
    end
  end
`else
  assign w_parked      = 1'b0;
  assign w_redirect_pc = redirect_pc & 32'hFFFF_FFFC;
`endif

  assign w_push      = (r_state == S_CAPT);
  assign w_pop       = (r_count != '0) && deq_ready;
  assign w_can_fetch = (r_count < DEPTH_C) && !w_parked;

  // Fetch sequencer: one word in flight, inst_read registered and high only in REQ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_read  <= 1'b0;
    end else if (redirect_valid) begin
      r_state <= S_IDLE;
      r_pc    <= w_redirect_pc;
      r_read  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_can_fetch) begin
            r_state <= S_REQ;
            r_read  <= 1'b1;
          end
        end
        S_REQ: begin
          r_state <= S_CAPT;
          r_read  <= 1'b0;
        end
        S_CAPT: begin
          r_state <= S_IDLE;
          r_pc    <= r_pc + 32'd4;
        end
        default: begin
          r_state <= S_IDLE;
          r_read  <= 1'b0;
        end
      endcase
    end
  end

  // Prefetch FIFO: redirect flushes by rewinding pointers; storage keeps its contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_inst_mem[i] <= '0;
        r_pc_mem[i]   <= '0;
      end
    end else if (redirect_valid) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_inst_mem[r_wr_ptr] <= inst_in;
        r_pc_mem[r_wr_ptr]   <= r_pc;
        r_wr_ptr             <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign inst_address = r_pc;
  assign inst_read    = r_read;
  assign fetch_valid  = (r_count != '0);
  assign fetch_inst   = r_inst_mem[r_rd_ptr];
  assign fetch_pc     = r_pc_mem[r_rd_ptr];
  assign fifo_count   = r_count;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed scenarios plus random traffic against a queue-based model.
module tb_inst_fetch_unit;

  localparam int          FIFO_DEPTH = 4;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] inst_address;
  logic        inst_read;
  logic [31:0] inst_in;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        deq_ready;
  logic        fetch_valid;
  logic [31:0] fetch_inst;
  logic [31:0] fetch_pc;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_fault;
`endif

  inst_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .inst_address(inst_address),
    .inst_read(inst_read),
    .inst_in(inst_in),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .deq_ready(deq_ready),
    .fetch_valid(fetch_valid),
    .fetch_inst(fetch_inst),
    .fetch_pc(fetch_pc),
    .fifo_count(fifo_count)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .fetch_fault(fetch_fault)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Instruction memory contents: two fixed words at 0 and 4, a hash elsewhere.
  function automatic logic [31:0] memword(input logic [31:0] a);
    if (a == 32'h0) return 32'hE081_3002;
    if (a == 32'h4) return 32'hE204_51B8;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  always @(posedge inst_read) inst_in <= memword(inst_address);

  // Reference model: a queue of {inst,pc} plus the age of the fetch in flight (0 = none).
  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_pc    = RESET_PC;
  int          m_age   = 0;
  bit          m_fault = 1'b0;

  task automatic model_update();
    int sz;
    if (!rst_n) begin
      m_q.delete();
      m_pc    = RESET_PC;
      m_age   = 0;
      m_fault = 1'b0;
    end else if (redirect_valid) begin
      m_q.delete();
      m_age = 0;
`ifdef FETCH_MISALIGN_TRAP_EN
      m_fault = (redirect_pc % 4) != 0;
      m_pc    = redirect_pc;
`else
      m_pc    = redirect_pc - (redirect_pc % 4);
`endif
    end else begin
      sz = m_q.size();
      if (sz != 0 && deq_ready) void'(m_q.pop_front());
      if (m_age == 2) begin
        m_q.push_back('{inst: memword(m_pc), pc: m_pc});
        m_pc  = m_pc + 32'd4;
        m_age = 0;
      end else if (m_age == 1) begin
        m_age = 2;
      end else if (sz < FIFO_DEPTH && !m_fault) begin
        m_age = 1;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_update();
  end

  // Per-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("addr", inst_address, m_pc);
      check("read", 32'(inst_read), 32'(m_age == 1));
      check("count", 32'(fifo_count), 32'(m_q.size()));
      check("valid", 32'(fetch_valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0) begin
        check("head_pc", fetch_pc, m_q[0].pc);
        check("head_inst", fetch_inst, m_q[0].inst);
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      check("fault", 32'(fetch_fault), 32'(m_fault));
`endif
    end
  end

  // Logs of observed read strobes and dequeued entries for the directed scenarios.
  logic [31:0] rd_addr[$];
  int          rd_cyc[$];
  logic [31:0] pop_pc[$];
  logic [31:0] pop_inst[$];
  int          cyc = 0;

  initial forever begin
    @(negedge clk);
    cyc++;
    if (inst_read) begin
      rd_addr.push_back(inst_address);
      rd_cyc.push_back(cyc);
    end
    if (fetch_valid && deq_ready && !redirect_valid && rst_n) begin
      pop_pc.push_back(fetch_pc);
      pop_inst.push_back(fetch_inst);
    end
  end

  function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic clear_logs();
    rd_addr.delete();
    rd_cyc.delete();
    pop_pc.delete();
    pop_inst.delete();
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step();
    redirect_valid = 1'b0;
    redirect_pc    = $urandom;
    clear_logs();
  endtask

  task automatic wait_read(input string nm);
    int n = 0;
    while (!inst_read && n < 12) begin
      step();
      n++;
    end
    check({nm, "_wait_read"}, 32'(inst_read), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    deq_ready      = 1'b0;
    inst_in        = 32'h0;
    run(3);

    check("rst_addr", inst_address, RESET_PC);
    check("rst_read", 32'(inst_read), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_valid", 32'(fetch_valid), 32'd0);
    check("rst_inst", fetch_inst, 32'd0);
    check("rst_pc", fetch_pc, 32'd0);
    chk_en = 1'b1;

    // Free-running fetch with the decoder always ready.
    deq_ready = 1'b1;
    rst_n     = 1'b1;
    clear_logs();
    run(12);
    check("s1_rd0", qat(rd_addr, 0), 32'h0);
    check("s1_rd1", qat(rd_addr, 1), 32'h4);
    check("s1_rd2", qat(rd_addr, 2), 32'h8);
    check("s1_spacing", 32'(rd_cyc.size() > 1 ? rd_cyc[1] - rd_cyc[0] : 0), 32'd3);
    check("s1_pop_pc0", qat(pop_pc, 0), 32'h0);
    check("s1_pop_inst0", qat(pop_inst, 0), 32'hE081_3002);
    check("s1_pop_pc1", qat(pop_pc, 1), 32'h4);
    check("s1_pop_inst1", qat(pop_inst, 1), 32'hE204_51B8);

    // Decoder stalled: fill to depth, then release one entry.
    deq_ready = 1'b0;
    redirect(32'h0);
    run(25);
    check("s2_nreads", 32'(rd_addr.size()), 32'd4);
    check("s2_rd3", qat(rd_addr, 3), 32'hC);
    check("s2_full", 32'(fifo_count), 32'd4);
    deq_ready = 1'b1;
    step();
    deq_ready = 1'b0;
    run(10);
    check("s2_nreads_more", 32'(rd_addr.size()), 32'd5);
    check("s2_rd4", qat(rd_addr, 4), 32'h10);
    check("s2_full_again", 32'(fifo_count), 32'd4);

    // Redirect while the read strobe is high.
    deq_ready = 1'b1;
    step();
    wait_read("s3");
    redirect(32'h20);
    check("s3_flushed", 32'(fifo_count), 32'd0);
    check("s3_read_low", 32'(inst_read), 32'd0);
    run(8);
    check("s3_rd0", qat(rd_addr, 0), 32'h20);
    check("s3_pop_pc0", qat(pop_pc, 0), 32'h20);

    // Redirect coinciding with a capture and a pop.
    deq_ready = 1'b0;
    redirect(32'h100);
    run(7);
    wait_read("s4");
    step();
    check("s4_capt_read_low", 32'(inst_read), 32'd0);
    check("s4_nonempty", 32'(fifo_count != 0), 32'd1);
    deq_ready = 1'b1;
    redirect(32'h200);
    deq_ready = 1'b0;
    check("s4_empty", 32'(fifo_count), 32'd0);
    check("s4_valid", 32'(fetch_valid), 32'd0);
    check("s4_addr", inst_address, 32'h200);

    // Address wrap at the top of memory.
    deq_ready = 1'b1;
    redirect(32'hFFFF_FFFC);
    run(8);
    check("s5_rd0", qat(rd_addr, 0), 32'hFFFF_FFFC);
    check("s5_rd1", qat(rd_addr, 1), 32'h0);
    check("s5_pop_pc0", qat(pop_pc, 0), 32'hFFFF_FFFC);
    check("s5_pop_pc1", qat(pop_pc, 1), 32'h0);

    // Misaligned redirect target.
    redirect(32'h13);
    run(8);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("s6_fault", 32'(fetch_fault), 32'd1);
    check("s6_nreads", 32'(rd_addr.size()), 32'd0);
    check("s6_addr", inst_address, 32'h13);
    redirect(32'h24);
    check("s6_fault_clr", 32'(fetch_fault), 32'd0);
    run(6);
    check("s6_rd0", qat(rd_addr, 0), 32'h24);
`else
    check("s6_rd0", qat(rd_addr, 0), 32'h10);
`endif

    // Asynchronous reset in the middle of a fetch.
    wait_read("s7");
    #1;
    rst_n = 1'b0;
    #1;
    check("s7_read_async", 32'(inst_read), 32'd0);
    check("s7_count", 32'(fifo_count), 32'd0);
    check("s7_addr", inst_address, RESET_PC);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    clear_logs();
    run(6);
    check("s7_rd0", qat(rd_addr, 0), RESET_PC);

    // Random traffic checked cycle by cycle against the model.
    for (int i = 0; i < 800; i++) begin
      if (i % 100 < 30) deq_ready = ($urandom_range(0, 3) == 0);
      else              deq_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 3))
        0:       redirect_pc = $urandom & 32'hFFFF_FFFC;
        1:       redirect_pc = $urandom;
        2:       redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'hC);
        default: redirect_pc = 32'($urandom_range(0, 64));
      endcase
      step();
    end
    redirect_valid = 1'b0;
    run(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Fetch-side initiator for the byte-addressed, big-endian instruction memory.
- Drives inst_address and inst_read. inst_read is a pulse; the memory loads inst_out on the rising edge of inst_read.
- Each returned word is captured together with its PC into a small prefetch FIFO, which feeds the decode stage through a valid/ready handshake.
- Handles branch redirects by flushing the FIFO and discarding any fetch in flight.

Parameters:
- RESET_PC, 32'h00000000, first fetch address after reset; must be word-aligned.
- FIFO_DEPTH, 4, number of prefetch entries; power of two, minimum 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- inst_address  output  32  byte address presented to the instruction memory.
- inst_read  output  1  read strobe; the memory samples on its rising edge.
- inst_in  input  32  instruction word from the memory, already big-endian assembled.
- redirect_valid  input  1  branch/exception redirect request, one cycle.
- redirect_pc  input  32  redirect target address.
- deq_ready  input  1  decode stage can accept an instruction this cycle.
- fetch_valid  output  1  FIFO head is valid.
- fetch_inst  output  32  FIFO head instruction.
- fetch_pc  output  32  FIFO head PC.
- fifo_count  output  clog2(FIFO_DEPTH)+1  current number of FIFO entries.

Behaviour:
- Reset (asynchronous on rst_n low):
  - pc=RESET_PC, inst_address=RESET_PC, inst_read=0.
  - FIFO empty: fifo_count=0, fetch_valid=0, fetch_inst=0, fetch_pc=0.
  - FSM in IDLE.
- Registered outputs: inst_address always equals the registered pc; inst_read comes from a register.
- FSM, one fetch in flight at a time, 3 cycles per word:
  - IDLE: inst_read=0. If fifo_count<FIFO_DEPTH and no redirect, go to REQ.
  - REQ: inst_read=1 for exactly one cycle; inst_address stays stable. Go to CAPT.
  - CAPT: inst_read=0. At the end of the cycle, push {inst_in, pc} into the FIFO, set pc=pc+4, go to IDLE.
- inst_address is held stable for the whole REQ and CAPT span. Address changes only on the CAPT exit or on a redirect.
- PC arithmetic is 32-bit modulo: 32'hFFFFFFFC + 4 wraps to 32'h00000000 with no flag.
- FIFO dequeue:
  - fetch_valid = (fifo_count != 0).
  - fetch_inst and fetch_pc show the head entry combinationally from registers.
  - The head pops on a cycle where fetch_valid && deq_ready.
- Full condition:
  - A new REQ starts only when fifo_count<FIFO_DEPTH.
  - Only one fetch is in flight, so a CAPT push never overflows.
  - A push and a pop in the same cycle leave fifo_count unchanged.
- Empty condition: a pop is ignored when fetch_valid=0.
- Redirect (redirect_valid=1), highest priority over push, pop and FSM progress:
  - FIFO flushed (count=0) and pc=redirect_pc with bits [1:0] forced to 0.
  - FSM returns to IDLE; any REQ/CAPT in flight is abandoned and its data dropped.
  - inst_read=0 on the next cycle.
  - A new REQ starts no earlier than the cycle after the redirect.
- Reset asserted mid-fetch: all state clears at once, inst_read drops to 0 asynchronously, and the in-flight word is lost.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- When defined:
  - Adds output fetch_fault (1 bit, reset 0).
  - A redirect with redirect_pc[1:0]!=0 sets fetch_fault=1, flushes the FIFO, loads pc=redirect_pc unmasked, and parks the FSM in IDLE with no further fetches.
  - Only a subsequent aligned redirect clears fetch_fault and resumes fetching.
- When undefined: no fetch_fault port; redirect_pc[1:0] is silently masked to 0.

Test Plan:
- Reset release, memory holds word 32'hE0813002 at address 0 and 32'hE20451B8 at address 4, deq_ready=1:
  - inst_read pulses at cycles 2 and 5.
  - fetch_valid shows pc=0/inst=32'hE0813002, then pc=4/inst=32'hE20451B8.
  - inst_address steps 0→4→8.
- deq_ready=0 with FIFO_DEPTH=4:
  - Exactly 4 words are fetched (addresses 0,4,8,C); fifo_count=4.
  - inst_read stays 0 thereafter.
  - Raising deq_ready for one cycle triggers exactly one more fetch at address 0x10.
- redirect_valid=1, redirect_pc=32'h00000020 asserted during REQ:
  - The in-flight word is not enqueued; fifo_count=0 next cycle.
  - The next inst_read pulse uses inst_address=0x20.
  - The first fetch_pc after that is 0x20.
- Simultaneous redirect, push (CAPT) and pop:
  - FIFO ends empty; pc=redirect target.
  - No stale entry ever appears on fetch_valid.
- redirect_pc=32'hFFFFFFFC:
  - Fetches 0xFFFFFFFC then 0x00000000 in order.
- redirect_pc=32'h00000013:
  - Undefined macro: fetch from 0x10.
  - Defined macro: fetch_fault=1 and no inst_read pulses; a later redirect to 0x24 clears fetch_fault and fetches 0x24.
